mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: mem_read  in  1  load in MEM stage; mem_write  in  1  store in MEM stage.
REQ-004 SHALL have: addr  in  64  byte address, doubleword-aligned; wdata  in  64  store data.
REQ-005 SHALL have: dmem_req  out  1  memory request; dmem_we  out  1  write enable; dmem_addr  out  64; dmem_wdata  out  64.
REQ-006 SHALL have: dmem_ack  in  1  one-cycle completion; dmem_rdata  in  64  read data, valid with dmem_ack.
REQ-007 SHALL have: ld_data  out  64  load result; ld_valid  out  1  one-cycle pulse; stall  out  1  freeze IF..MEM.

Function
REQ-008 SHALL implement states IDLE, RD_WAIT, WR_WAIT and, with the store buffer, DRAIN.
REQ-009 SHALL, when mem_read and mem_write are both high, serve the load and ignore the store.
REQ-010 IDLE + load (no buffer hit): SHALL register addr, set dmem_req=1, dmem_we=0 from the next cycle, go to RD_WAIT.
REQ-011 IDLE + store (buffer off): SHALL register addr/wdata, set dmem_req=1, dmem_we=1 from the next cycle, go to WR_WAIT.
REQ-012 dmem_req, dmem_we, dmem_addr, dmem_wdata SHALL be held stable until the dmem_ack cycle and drop the cycle after.
REQ-013 RD_WAIT + dmem_ack: SHALL register dmem_rdata into ld_data, pulse ld_valid the following cycle, return to IDLE.
REQ-014 WR_WAIT + dmem_ack: SHALL return to IDLE; ld_valid stays 0.
REQ-015 stall (combinational) SHALL be 1 in IDLE when a request needs memory, and in RD_WAIT/WR_WAIT while dmem_ack=0; 0 in the dmem_ack cycle.
REQ-016 Minimum load/store latency: SHALL be 2 cycles (request cycle + ack cycle) with an ack on the first dmem_req cycle.
REQ-017 ld_data SHALL hold its last value between loads.

Reset
REQ-018 Reset SHALL immediately force IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, ld_data=0, ld_valid=0, and clear the store buffer.
REQ-019 stall SHALL be 0 while reset is high.
REQ-020 Reset mid-transaction SHALL abandon it with no retry; a late dmem_ack after reset SHALL be ignored; buffered store data is lost.

Configuration
REQ-021 Macro STORE_BUF_EN SHALL compile in a one-entry store buffer (valid, addr, data).
REQ-022 With STORE_BUF_EN: a store with the buffer empty (or freed in that dmem_ack cycle) SHALL be written to the buffer with stall=0.
REQ-023 With STORE_BUF_EN: a store with the buffer full and not draining SHALL stall until the drain's dmem_ack.
REQ-024 With STORE_BUF_EN: a load whose addr equals the buffer addr (buffer valid) SHALL return buffer data in ld_data with ld_valid the next cycle, no memory access, and stall=0.
REQ-025 With STORE_BUF_EN: a buffer-missing load in IDLE SHALL be issued before the drain; IDLE with a valid buffer and no load SHALL go to DRAIN (dmem_we=1 from the next cycle).
REQ-026 In DRAIN: dmem_ack SHALL clear the buffer and return to IDLE; a buffer-missing load arriving in DRAIN SHALL stall until the drain's dmem_ack, then issue as in REQ-010.
REQ-027 Without STORE_BUF_EN: every store SHALL take the WR_WAIT path, and DRAIN and the buffer logic SHALL not exist.

Verification
REQ-028 Load addr=0x100, dmem_ack 3 cycles after dmem_req, rdata=0xDEAD -> stall high 4 cycles, ld_data=0xDEAD, ld_valid one pulse.
REQ-029 mem_read=mem_write=1, addr=0x40 -> one read request (dmem_we=0), no write issued.
REQ-030 Buffer on: store 0x80 <- 0x1234, next cycle load 0x80 -> stall=0 both cycles, ld_data=0x1234, no dmem_req for the load.
REQ-031 Buffer on: two back-to-back stores to 0x80 and 0x88 -> second stalls until drain ack of 0x80, then buffered; 0x88 drained later.
REQ-032 Reset asserted in RD_WAIT, dmem_ack arrives after release -> dmem_req=0 at once, ld_valid stays 0, IDLE.
REQ-033 Buffer off: store 0x10 <- 0x5, ack on first request cycle -> stall exactly 1 cycle, dmem_we=1 for 1 cycle, ld_valid=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: loads, stores, pipeline stall.
// Define STORE_BUF_EN to add a one-entry store buffer drained through DRAIN.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] ld_data,
  output logic        ld_valid,
  output logic        stall
);

`ifdef STORE_BUF_EN
  typedef enum logic [1:0] {
    IDLE, RD_WAIT, WR_WAIT, DRAIN
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, RD_WAIT, WR_WAIT
  } state_t;
`endif

  state_t state;

`ifdef STORE_BUF_EN
  logic        buf_valid;
  logic [63:0] buf_addr;
  logic [63:0] buf_data;
  logic        buf_hit;
  logic        wr_req;

  assign buf_hit = buf_valid && (addr == buf_addr);
  assign wr_req  = mem_write && !mem_read;
`endif

  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
`ifdef STORE_BUF_EN
          stall = mem_read ? !buf_hit
                           : (mem_write && buf_valid);
`else
          stall = mem_read || mem_write;
`endif
        end
        RD_WAIT: stall = !dmem_ack;
        WR_WAIT: stall = !dmem_ack;
`ifdef STORE_BUF_EN
        // a missing load waits out the drain and then re-enters IDLE
        DRAIN: stall = mem_read ? !buf_hit
                                : (mem_write && !dmem_ack);
`endif
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      ld_data    <= '0;
      ld_valid   <= 1'b0;
`ifdef STORE_BUF_EN
      buf_valid  <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
`endif
    end else begin
      ld_valid <= 1'b0;
      unique case (state)
        IDLE: begin
`ifdef STORE_BUF_EN
          if (mem_read && buf_hit) begin
            ld_data  <= buf_data;
            ld_valid <= 1'b1;
          end else if (mem_read) begin
            state     <= RD_WAIT;
            dmem_req  <= 1'b1;
            dmem_we   <= 1'b0;
            dmem_addr <= addr;
          end else if (mem_write && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_addr  <= addr;
            buf_data  <= wdata;
          end else if (buf_valid) begin
            state      <= DRAIN;
            dmem_req   <= 1'b1;
            dmem_we    <= 1'b1;
            dmem_addr  <= buf_addr;
            dmem_wdata <= buf_data;
          end
`else
          if (mem_read) begin
            state     <= RD_WAIT;
            dmem_req  <= 1'b1;
            dmem_we   <= 1'b0;
            dmem_addr <= addr;
          end else if (mem_write) begin
            state      <= WR_WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= 1'b1;
            dmem_addr  <= addr;
            dmem_wdata <= wdata;
          end
`endif
        end
        RD_WAIT: begin
          if (dmem_ack) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            ld_data    <= dmem_rdata;
            ld_valid   <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (dmem_ack) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
          end
        end
`ifdef STORE_BUF_EN
        DRAIN: begin
          if (mem_read && buf_hit) begin
            ld_data  <= buf_data;
            ld_valid <= 1'b1;
          end
          if (dmem_ack) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            // the freed entry takes a waiting store
            buf_valid  <= wr_req;
            if (wr_req) begin
              buf_addr <= addr;
              buf_data <= wdata;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: program-order memory model,
// directed latency/reset cases and a randomized load/store stream.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [63:0] addr, wdata;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic [63:0] ld_data;
  logic        ld_valid, stall;

  mem_access_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0]  ref_mem  [logic [63:0]];
  logic [63:0]  phys_mem [logic [63:0]];
  logic [63:0]  exp_ld [$];
  logic [127:0] exp_wr [$];

  logic resp_en  = 1'b1;
  logic rand_lat = 1'b0;
  int   ack_lat  = 0;
  int   wait_cnt = 0;
  int   n_rd_ack = 0;
  int   n_wr_ack = 0;
  int   n_we_cyc = 0;
  logic [127:0] ew;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] phys_rd(input logic [63:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : 64'h0;
  endfunction

  // memory responder; also checks every committed write in order
  always @(negedge clk) begin
    if (dmem_we) n_we_cyc++;
    if (resp_en && !reset && dmem_req) begin
      if (wait_cnt >= ack_lat) begin
        dmem_ack = 1'b1;
        wait_cnt = 0;
        if (dmem_we) begin
          n_wr_ack++;
          phys_mem[dmem_addr] = dmem_wdata;
          if (exp_wr.size() == 0) check("wr_spurious", dmem_we, 1'b0);
          else begin
            ew = exp_wr.pop_front();
            check("wr_addr", dmem_addr, ew[127:64]);
            check("wr_data", dmem_wdata, ew[63:0]);
          end
        end else begin
          n_rd_ack++;
          dmem_rdata = phys_rd(dmem_addr);
        end
        if (rand_lat) ack_lat = $urandom_range(0, 3);
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = {$urandom, $urandom};
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (resp_en) begin
        dmem_ack   = 1'b0;
        dmem_rdata = {$urandom, $urandom};
      end
    end
  end

  // load-result monitor
  always @(negedge clk) begin
    if (!reset && ld_valid) begin
      if (exp_ld.size() == 0) check("ld_spurious", ld_valid, 1'b0);
      else check("ld_data", ld_data, exp_ld.pop_front());
    end
  end

  // call at posedge+1; returns at posedge+1 after the op is accepted
  task automatic issue(input logic rd, input logic wr,
                       input logic [63:0] a, input logic [63:0] d,
                       output int stalls);
    stalls    = 0;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    if (rd) exp_ld.push_back(ref_rd(a));
    else if (wr) begin
      ref_mem[a] = d;
      exp_wr.push_back({a, d});
    end
    forever begin
      @(negedge clk); #1;
      if (!stall) break;
      stalls++;
      if (stalls > 200) begin
        check("issue_timeout", stall, 1'b0);
        break;
      end
    end
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, st2, r0, w0, we0;
    reset = 1'b1;
    mem_read = 1'b1; mem_write = 1'b1;
    addr = 64'h123; wdata = 64'h456;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", dmem_req, 1'b0);
    check("rst_we", dmem_we, 1'b0);
    check("rst_addr", dmem_addr, 64'h0);
    check("rst_wdata", dmem_wdata, 64'h0);
    check("rst_ld_data", ld_data, 64'h0);
    check("rst_ld_valid", ld_valid, 1'b0);
    check("rst_stall", stall, 1'b0);
    mem_read = 1'b0; mem_write = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // load with ack three cycles after the request
    phys_mem[64'h100] = 64'hDEAD;
    ref_mem[64'h100]  = 64'hDEAD;
    ack_lat = 3;
    issue(1'b1, 1'b0, 64'h100, 64'h0, st);
    check("ld_lat3_stall", st, 4);
    repeat (3) @(negedge clk);
    check("ld_hold", ld_data, 64'hDEAD);
    check("ld_pulse_end", ld_valid, 1'b0);
    #1;

    // load and store together: only the load reaches memory
    ack_lat = 1;
    r0 = n_rd_ack; w0 = n_wr_ack;
    issue(1'b1, 1'b1, 64'h40, 64'h77, st);
    idle(4);
    check("both_rd", n_rd_ack - r0, 1);
    check("both_wr", n_wr_ack - w0, 0);

`ifdef STORE_BUF_EN
    // store then load to the same address: served from the buffer
    ack_lat = 1;
    r0 = n_rd_ack;
    issue(1'b0, 1'b1, 64'h80, 64'h1234, st);
    issue(1'b1, 1'b0, 64'h80, 64'h0, st2);
    check("sb_st_stall", st, 0);
    check("sb_hit_stall", st2, 0);
    idle(10);
    check("sb_hit_no_rd", n_rd_ack - r0, 0);
    check("sb_drained", phys_rd(64'h80), 64'h1234);

    // back-to-back stores: the second waits for the first drain
    ack_lat = 2;
    issue(1'b0, 1'b1, 64'h80, 64'hAAAA, st);
    issue(1'b0, 1'b1, 64'h88, 64'hBBBB, st2);
    check("sb2_st1_stall", st, 0);
    check("sb2_st2_stall", st2, 3);
    check("sb2_first", phys_rd(64'h80), 64'hAAAA);
    idle(10);
    check("sb2_second", phys_rd(64'h88), 64'hBBBB);
`else
    // unbuffered store acked on its first request cycle
    ack_lat = 0;
    we0 = n_we_cyc;
    issue(1'b0, 1'b1, 64'h10, 64'h5, st);
    idle(3);
    check("st_stall", st, 1);
    check("st_we_cycles", n_we_cyc - we0, 1);
    check("st_mem", phys_rd(64'h10), 64'h5);
`endif

    // reset while a read is outstanding; the late ack is ignored
    idle(5);
    resp_en = 1'b0;
    dmem_ack = 1'b0;
    mem_read = 1'b1; addr = 64'h200;
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_req_before", dmem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("rr_req_drop", dmem_req, 1'b0);
    check("rr_stall", stall, 1'b0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 64'hBAD;
    @(negedge clk); #1;
    dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_ld_valid", ld_valid, 1'b0);
    check("rr_ld_data", ld_data, 64'h0);
    check("rr_req_after", dmem_req, 1'b0);
    resp_en = 1'b1;

    // randomized stream against the program-order model
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ld.delete(); exp_wr.delete();
    ref_mem.delete(); phys_mem.delete();
    rand_lat = 1'b1;
    ack_lat = $urandom_range(0, 3);
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [63:0] a, d;
      op = $urandom_range(0, 9);
      a  = 64'($urandom_range(0, 7)) << 3;
      d  = {$urandom, $urandom};
      if (op < 4)       issue(1'b1, 1'b0, a, d, st);
      else if (op < 8)  issue(1'b0, 1'b1, a, d, st);
      else if (op == 8) issue(1'b1, 1'b1, a, d, st);
      else              idle(1);
    end
    idle(20);
    check("ld_queue_empty", 64'(exp_ld.size()), 64'h0);
    check("wr_queue_empty", 64'(exp_wr.size()), 64'h0);
    for (int k = 0; k < 8; k++) begin
      logic [63:0] ka;
      ka = 64'(k) << 3;
      check("mem_final", phys_rd(ka), ref_rd(ka));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
